fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 38 +++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its decoder consumer.
// Holds RV32I 5-bit major opcodes (inst[6:2]), func3/func7 values and the
// fetch FSM state encoding.
package fetch_unit_pkg;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OpcodeOp     = 5'b01100;
  localparam logic [4:0] OpcodeOpImm  = 5'b00100;
  localparam logic [4:0] OpcodeLoad   = 5'b00000;
  localparam logic [4:0] OpcodeStore  = 5'b01000;
  localparam logic [4:0] OpcodeLui    = 5'b01101;
  localparam logic [4:0] OpcodeJal    = 5'b11011;
  localparam logic [4:0] OpcodeJalr   = 5'b11001;
  localparam logic [4:0] OpcodeBranch = 5'b11000;

  // func3 values for OP / OP_IMM
  localparam logic [2:0] Func3AddSub = 3'b000;
  localparam logic [2:0] Func3Sll    = 3'b001;
  localparam logic [2:0] Func3Slt    = 3'b010;
  localparam logic [2:0] Func3Sltu   = 3'b011;
  localparam logic [2:0] Func3Xor    = 3'b100;
  localparam logic [2:0] Func3SrlSra = 3'b101;
  localparam logic [2:0] Func3Or     = 3'b110;
  localparam logic [2:0] Func3And    = 3'b111;

  // func7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] Func7Base = 7'b0000000;
  localparam logic [6:0] Func7Alt  = 7'b0100000;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one word fetch at a time to
// instruction memory and hands each returned word, with its PC and decode
// field slices, to the decoder over a valid/ready handshake. Redirects load a
// new PC; a fetch already in flight at that point is drained and dropped.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel (word-aligned address)
//   imem_rsp_valid/data          fetch response, one per accepted request
//   inst_valid/ready             instruction handshake to the decoder
//   inst, inst_pc                registered instruction word and its PC
//   opcode, func3, func7         slices of inst
//   illegal                      inst[1:0] != 2'b11 (forwarded, not acted on)
//   redirect_valid/pc            taken branch/jump target (bits [1:0] ignored)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        illegal,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    if (redirect_valid) begin
      // Redirect wins over every other event; any response seen now is stale.
      pc_d = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        StIdle:  state_d = StReq;
        StReq:   state_d = imem_req_ready ? StDrain : StReq;
        StWait:  state_d = imem_rsp_valid ? StReq : StDrain;
        StHold:  state_d = StReq;
        StDrain: state_d = imem_rsp_valid ? StReq : StDrain;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_req_ready) state_d = StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = StHold;
          end
        end
        StHold: begin
          if (inst_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = StReq;
          end
        end
        StDrain: begin
          if (imem_rsp_valid) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == StHold);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign opcode         = inst_q[6:2];
  assign func3          = inst_q[14:12];
  assign func7          = inst_q[31:25];
  assign illegal        = (inst_q[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Each table row is one clock cycle: inputs are
// driven and registered outputs are compared at the falling edge, so the
// expected values are those of the state reached by the previous rising edge.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(RstPc)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .func3          (func3),
    .func7          (func7),
    .illegal        (illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] rd;
    bit          ir;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rqv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input bit chk, input bit r, input bit rdy, input bit rv,
                     input logic [31:0] rd, input bit ir, input bit redir,
                     input logic [31:0] rpc, input bit e_rqv, input logic [31:0] e_addr,
                     input bit e_iv, input logic [31:0] e_inst, input logic [31:0] e_ipc);
    vec_t v;
    v.chk = chk; v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
    v.redir = redir; v.rpc = rpc; v.e_rqv = e_rqv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input bit e_rqv, input logic [31:0] e_addr,
                               input bit e_iv, input logic [31:0] e_inst,
                               input logic [31:0] e_ipc);
    string tag;
    tag = $sformatf("row%0d", idx);
    check({tag, " req_valid"}, {31'h0, imem_req_valid}, {31'h0, e_rqv});
    check({tag, " req_addr"}, imem_req_addr, e_addr);
    check({tag, " inst_valid"}, {31'h0, inst_valid}, {31'h0, e_iv});
    check({tag, " inst"}, inst, e_inst);
    check({tag, " inst_pc"}, inst_pc, e_ipc);
    check({tag, " opcode"}, {27'h0, opcode}, {27'h0, e_inst[6:2]});
    check({tag, " func3"}, {29'h0, func3}, {29'h0, e_inst[14:12]});
    check({tag, " func7"}, {25'h0, func7}, {25'h0, e_inst[31:25]});
    check({tag, " illegal"}, {31'h0, illegal}, {31'h0, e_inst[1:0] != 2'b11});
  endtask

  initial begin
    bit got;
    bit pend;

    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    //   chk rst rdy rv rd            ir rdr rpc           | rqv addr          iv inst          ipc
    add(0, 1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    // Cycle 0 IDLE, cycle 1 request, cycle 2 response, cycle 3 inst_valid
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 1, 32'h0000_0533,  1, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,      1, 32'h0000_0533, 32'h100);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,      0, 32'h0000_0533, 32'h100);
    add(1, 0, 1, 1, 32'h0,          1, 0, 32'h0,          0, 32'h104,      0, 32'h0000_0533, 32'h100);
    // All-zero word held with inst_ready low for 4 cycles
    for (int i = 0; i < 4; i++)
      add(1, 0, 1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h104,      1, 32'h0,        32'h104);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h104,      1, 32'h0,        32'h104);
    add(1, 0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h108,      0, 32'h0,        32'h104);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h108,      0, 32'h0,        32'h104);
    // Redirect to 0x203 in WAIT, stale response 3 cycles later
    add(1, 0, 1, 0, 32'h0,          1, 1, 32'h203,        0, 32'h108,      0, 32'h0,        32'h104);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h200,      0, 32'h0,        32'h104);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h200,      0, 32'h0,        32'h104);
    add(1, 0, 1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h200,      0, 32'h0,        32'h104);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,      0, 32'h0,        32'h104);
    add(1, 0, 1, 1, 32'h00A0_0093,  1, 0, 32'h0,          0, 32'h200,      0, 32'h0,        32'h104);
    // Redirect together with inst_ready in HOLD: target wins over pc+4
    add(1, 0, 1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h200,      1, 32'h00A0_0093, 32'h200);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h00A0_0093, 32'h200);
    add(1, 0, 1, 1, 32'h40B5_0533,  1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h00A0_0093, 32'h200);
    // PC wraps from 0xFFFF_FFFC to 0
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h40B5_0533, 32'hFFFF_FFFC);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,        0, 32'h40B5_0533, 32'hFFFF_FFFC);
    // Redirect in WAIT -> DRAIN, then reset while the response is pending
    add(1, 0, 1, 0, 32'h0,          1, 1, 32'h300,        0, 32'h0,        0, 32'h40B5_0533, 32'hFFFF_FFFC);
    add(1, 1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h300,      0, 32'h40B5_0533, 32'hFFFF_FFFC);
    // Late response lands in IDLE and must be ignored
    add(1, 0, 1, 1, 32'h1234_5678,  1, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 1, 32'h0000_0533,  1, 0, 32'h0,          0, 32'h100,      0, 32'h0,        32'h0);
    add(1, 0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,      1, 32'h0000_0533, 32'h100);
    // Redirect in REQ with request not accepted: stay in REQ at new address
    add(1, 0, 0, 0, 32'h0,          1, 1, 32'h55,         1, 32'h104,      0, 32'h0000_0533, 32'h100);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rd;
      inst_ready     = vecs[i].ir;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      if (vecs[i].chk)
        check_outputs(i, vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_inst,
                      vecs[i].e_ipc);
    end

    // Redirect in REQ while the request is accepted -> DRAIN
    @(negedge clk);
    check("redir_req_hold valid", {31'h0, imem_req_valid}, 32'h1);
    check("redir_req_hold addr", imem_req_addr, 32'h54);
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    check("redir_req_acc drain", {31'h0, imem_req_valid}, 32'h0);
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("drain_done valid", {31'h0, imem_req_valid}, 32'h1);
    check("drain_done addr", imem_req_addr, 32'h80);
    imem_rsp_valid = 1'b0;
    // Redirect in WAIT with the response in the same cycle -> REQ, data dropped
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD1_BAD1;
    redirect_valid = 1'b1; redirect_pc = 32'h91;
    @(negedge clk);
    check("redir_wait_rsp valid", {31'h0, imem_req_valid}, 32'h1);
    check("redir_wait_rsp addr", imem_req_addr, 32'h90);
    check("redir_wait_rsp inst", inst, 32'h0000_0533);
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;

    // Small one-cycle-latency memory model, bounded wait for the instruction
    got  = 1'b0;
    pend = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        got = 1'b1;
        break;
      end
      imem_rsp_valid = pend;
      imem_rsp_data  = 32'h0000_0013;
      pend           = imem_req_valid;
    end
    check("refetch arrived", {31'h0, got}, 32'h1);
    check("refetch inst", inst, 32'h0000_0013);
    check("refetch inst_pc", inst_pc, 32'h90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
